// File: rtl/settings_menu_fsm.sv
// Pre-game settings menu: maps debounced key presses to sound/theme/hearts choices,
// the row cursor and the game_started flag. Define AUTO_REPEAT_EN for held-key auto-repeat.
module settings_menu_fsm #(
  parameter int HEARTS_MIN     = 1,
  parameter int HEARTS_MAX     = 6,
`ifdef AUTO_REPEAT_EN
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_PERIOD  = 6_250_000,
`endif
  parameter int HEARTS_DEFAULT = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_enter,
  input  logic       game_over,
  output logic       sound_choice,
  output logic       theme_choice,
  output logic [2:0] hearts_choice,
  output logic [1:0] cursor,
  output logic       menu_active,
  output logic       game_started
);

  typedef enum logic [1:0] {S_MENU, S_PLAYING, S_RELEASE} state_t;

  localparam logic [1:0] ROW_SOUND  = 2'd0;
  localparam logic [1:0] ROW_THEME  = 2'd1;
  localparam logic [1:0] ROW_HEARTS = 2'd2;
  localparam logic [1:0] ROW_START  = 2'd3;
  localparam logic [2:0] H_MIN = 3'(HEARTS_MIN);
  localparam logic [2:0] H_MAX = 3'(HEARTS_MAX);
  localparam logic [2:0] H_DEF = 3'(HEARTS_DEFAULT);

  // Key vector order: [0]=up [1]=down [2]=left [3]=right [4]=enter.
  logic [4:0] keys, key_prev, press, events;
  state_t     state_q, state_d;
  logic       sound_d, theme_d, menu_active_d, game_started_d;
  logic [2:0] hearts_d;
  logic [1:0] cursor_d;

  assign keys  = {key_enter, key_right, key_left, key_down, key_up};
  assign press = keys & ~key_prev;

`ifdef AUTO_REPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY + 1);

  logic [CW-1:0] rpt_cnt, rpt_cnt_d;
  logic          rpt_alone, rpt_fire;

  // rpt_cnt holds the number of edges the lone key has been held, counting the press edge as 1.
  // After each fire it is rewound so the next fire lands REPEAT_PERIOD edges later.
  always_comb begin
    rpt_alone = (state_q == S_MENU) && !key_enter && $onehot(keys[3:0]);
    rpt_fire  = 1'b0;
    rpt_cnt_d = '0;
    if (rpt_alone) begin
      if (keys != key_prev) begin
        rpt_cnt_d = CW'(1);
      end else if (rpt_cnt == CW'(REPEAT_DELAY)) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = CW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      end else begin
        rpt_cnt_d = rpt_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rpt_cnt <= '0;
    else         rpt_cnt <= rpt_cnt_d;
  end

  assign events = press | (rpt_fire ? keys : 5'b0);
`else
  assign events = press;
`endif

  // NOTE: every variable gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    sound_d  = sound_choice;
    theme_d  = theme_choice;
    hearts_d = hearts_choice;
    cursor_d = cursor;
    unique case (state_q)
      S_MENU: begin
        if (events[4]) begin
          if (cursor == ROW_SOUND)      sound_d = ~sound_choice;
          else if (cursor == ROW_THEME) theme_d = ~theme_choice;
          else if (cursor == ROW_START) state_d = S_PLAYING;
        end else if (events[0]) begin
          cursor_d = cursor - 2'd1;
        end else if (events[1]) begin
          cursor_d = cursor + 2'd1;
        end else if (events[2]) begin
          if (cursor == ROW_SOUND)      sound_d = ~sound_choice;
          else if (cursor == ROW_THEME) theme_d = ~theme_choice;
          else if (cursor == ROW_HEARTS && hearts_choice > H_MIN) hearts_d = hearts_choice - 3'd1;
        end else if (events[3]) begin
          if (cursor == ROW_SOUND)      sound_d = ~sound_choice;
          else if (cursor == ROW_THEME) theme_d = ~theme_choice;
          else if (cursor == ROW_HEARTS && hearts_choice < H_MAX) hearts_d = hearts_choice + 3'd1;
        end
      end
      S_PLAYING: begin
        if (game_over) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold off the menu until every key is up, so a key held from the game is not read as input.
        if (keys == 5'b0) begin
          state_d  = S_MENU;
          cursor_d = ROW_START;
        end
      end
      default: state_d = S_MENU;
    endcase
    menu_active_d  = (state_d == S_MENU);
    game_started_d = (state_d == S_PLAYING);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_MENU;
      key_prev      <= '0;
      sound_choice  <= 1'b0;
      theme_choice  <= 1'b0;
      hearts_choice <= H_DEF;
      cursor        <= ROW_SOUND;
      menu_active   <= 1'b1;
      game_started  <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_prev      <= keys;
      sound_choice  <= sound_d;
      theme_choice  <= theme_d;
      hearts_choice <= hearts_d;
      cursor        <= cursor_d;
      menu_active   <= menu_active_d;
      game_started  <= game_started_d;
    end
  end

endmodule

// File: tb/tb_settings_menu_fsm.sv
// Scoreboard bench for settings_menu_fsm: a behavioural menu model predicts every cycle's outputs;
// a monitor compares them after each clock edge. Honours AUTO_REPEAT_EN when defined.
module tb_settings_menu_fsm;

  localparam int H_MIN = 1;
  localparam int H_MAX = 6;
  localparam int H_DEF = 3;
`ifdef AUTO_REPEAT_EN
  localparam int R_DELAY  = 10;
  localparam int R_PERIOD = 4;
`endif

  localparam bit [4:0] K_UP = 5'b00001, K_DOWN = 5'b00010, K_LEFT = 5'b00100,
                       K_RIGHT = 5'b01000, K_ENTER = 5'b10000;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_enter = 1'b0;
  logic       game_over = 1'b0;
  logic       sound_choice, theme_choice, menu_active, game_started;
  logic [2:0] hearts_choice;
  logic [1:0] cursor;
  logic [8:0] outs;

  settings_menu_fsm #(
    .HEARTS_MIN(H_MIN),
    .HEARTS_MAX(H_MAX),
`ifdef AUTO_REPEAT_EN
    .REPEAT_DELAY(R_DELAY),
    .REPEAT_PERIOD(R_PERIOD),
`endif
    .HEARTS_DEFAULT(H_DEF)
  ) dut (
    .clk(clk), .resetN(resetN),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_enter(key_enter), .game_over(game_over),
    .sound_choice(sound_choice), .theme_choice(theme_choice), .hearts_choice(hearts_choice),
    .cursor(cursor), .menu_active(menu_active), .game_started(game_started)
  );

  always #5 clk = ~clk;

  assign outs = {sound_choice, theme_choice, hearts_choice, cursor, menu_active, game_started};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: menu mode flags, row index 0..3, hearts as plain integers.
  bit       m_sound, m_theme, m_playing, m_release;
  int       m_hearts, m_cursor, m_age;
  bit [4:0] m_prev;
  logic [8:0] exp_q[$];

  function automatic logic [8:0] model_outs();
    return {m_sound, m_theme, 3'(m_hearts), 2'(m_cursor), !(m_playing || m_release), m_playing};
  endfunction

  function automatic logic [8:0] reset_outs();
    return {1'b0, 1'b0, 3'(H_DEF), 2'd0, 1'b1, 1'b0};
  endfunction

  task automatic toggle_row();
    if (m_cursor == 0)      m_sound = !m_sound;
    else if (m_cursor == 1) m_theme = !m_theme;
  endtask

  task automatic model_step(input bit rst_n, input bit [4:0] k, input bit go);
    bit [4:0] ev;
    bit       in_menu;
    if (!rst_n) begin
      m_sound = 0; m_theme = 0; m_hearts = H_DEF; m_cursor = 0;
      m_playing = 0; m_release = 0; m_prev = '0; m_age = 0;
      return;
    end
    in_menu = !m_playing && !m_release;
    ev = k & ~m_prev;
`ifdef AUTO_REPEAT_EN
    if (in_menu && !k[4] && $countones(k[3:0]) == 1 && k == m_prev) begin
      m_age++;
      if (m_age >= R_DELAY && (m_age - R_DELAY) % R_PERIOD == 0) ev = k;
    end else begin
      m_age = 0;
    end
`endif
    if (in_menu) begin
      if (ev[4]) begin
        if (m_cursor == 3) m_playing = 1;
        else toggle_row();
      end else if (ev[0]) m_cursor = (m_cursor + 3) % 4;
      else if (ev[1]) m_cursor = (m_cursor + 1) % 4;
      else if (ev[2]) begin
        if (m_cursor == 2) m_hearts = (m_hearts > H_MIN) ? m_hearts - 1 : H_MIN;
        else toggle_row();
      end else if (ev[3]) begin
        if (m_cursor == 2) m_hearts = (m_hearts < H_MAX) ? m_hearts + 1 : H_MAX;
        else toggle_row();
      end
    end else if (m_playing) begin
      if (go) begin m_playing = 0; m_release = 1; end
    end else if (k == 0) begin
      m_release = 0;
      m_cursor  = 3;
    end
    m_prev = k;
  endtask

  // One clock of stimulus: drive at the falling edge, predict the post-edge outputs.
  task automatic cyc(input bit [4:0] k, input bit go, input bit rst_n);
    @(negedge clk);
    resetN = rst_n;
    {key_enter, key_right, key_left, key_down, key_up} = k;
    game_over = go;
    model_step(rst_n, k, go);
    exp_q.push_back(model_outs());
    if (!rst_n) begin
      #1 check("async_reset", outs, reset_outs());
    end
  endtask

  task automatic tap(input bit [4:0] k);
    cyc(k, 1'b0, 1'b1);
    cyc(5'b0, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", outs, e);
      end
    end
  end

  initial begin : stimulus
    bit [4:0] k;
    int       hold, n;
    cyc(5'b0, 1'b0, 1'b0);
    cyc(5'b0, 1'b0, 1'b0);
    cyc(5'b0, 1'b0, 1'b1);
    check("t1_reset_state", outs, reset_outs());

    tap(K_DOWN);
    tap(K_DOWN);
    check("t2_cursor", cursor, 2);
    for (int i = 0; i < 5; i++) begin
      tap(K_RIGHT);
      check("t2_hearts_up", hearts_choice, (4 + i > H_MAX) ? H_MAX : 4 + i);
    end
    for (int i = 0; i < 6; i++) tap(K_LEFT);
    check("t2_hearts_min", hearts_choice, H_MIN);

    tap(K_UP);
    tap(K_UP);
    check("t3_cursor0", cursor, 0);
    tap(K_UP);
    check("t3_wrap", cursor, 3);
    tap(K_ENTER);
    check("t3_started", {menu_active, game_started}, 2'b01);
    tap(K_RIGHT);
    tap(K_UP);
    check("t3_frozen", {hearts_choice, cursor, game_started}, {3'(H_MIN), 2'd3, 1'b1});

    cyc(K_RIGHT, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(K_RIGHT, 1'b0, 1'b1);
    check("t4_release", {menu_active, game_started}, 2'b00);
    cyc(5'b0, 1'b0, 1'b1);
    cyc(5'b0, 1'b0, 1'b1);
    check("t4_menu", {menu_active, game_started, cursor, hearts_choice, sound_choice},
          {1'b1, 1'b0, 2'd3, 3'(H_MIN), 1'b0});

    tap(K_DOWN);
    cyc(K_UP | K_ENTER, 1'b0, 1'b1);
    cyc(5'b0, 1'b0, 1'b1);
    check("t5_priority", {sound_choice, cursor}, {1'b1, 2'd0});

    tap(K_DOWN);
    tap(K_DOWN);
    for (int i = 0; i < 20; i++) cyc(K_RIGHT, 1'b0, 1'b1);
    cyc(5'b0, 1'b0, 1'b1);
`ifdef AUTO_REPEAT_EN
    check("t6_hold_hearts", hearts_choice, 5);
`else
    check("t6_hold_hearts", hearts_choice, 2);
`endif

    n = 0;
    while (n < 4000) begin
      case ($urandom_range(0, 7))
        0, 1, 2: k = 5'b0;
        3, 4, 5: k = 5'(1 << $urandom_range(0, 4));
        default: k = 5'($urandom_range(0, 31));
      endcase
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 4);
      for (int j = 0; j < hold; j++) begin
        cyc(k, ($urandom_range(0, 15) == 0), ($urandom_range(0, 599) != 0));
        n++;
      end
    end

    cyc(5'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
